cla_add32_pipe: RTL and testbench



---
 rtl/cla_add32_pipe_pkg.sv | 36 +++
 rtl/cla_add32_pipe_if.sv | 27 ++
 rtl/cla_add32_pipe_cla16.sv | 58 +++++
 rtl/cla_add32_pipe.sv | 118 +++++++++++
 tb/tb_cla_add32_pipe.sv | 307 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/cla_add32_pipe_pkg.sv
// Shared constants and stage-register records for the two-stage 32-bit CLA adder.
package cla_add32_pipe_pkg;

    localparam int CLA_HALF  = 16;
    localparam int CLA_WIDTH = 2 * CLA_HALF;

    // Stage-1 record field widths
    localparam int S1_LO_W   = CLA_HALF;
    localparam int S1_C16_W  = 1;
    localparam int S1_HI_W   = CLA_HALF;
    localparam int S1_SIGN_W = 1;

    // Low-half result plus everything the high half still needs.
    typedef struct packed {
        logic [S1_LO_W-1:0]   lo_sum;
        logic [S1_C16_W-1:0]  c16;
        logic [S1_HI_W-1:0]   a_hi;
        logic [S1_HI_W-1:0]   b_hi;
        logic [S1_SIGN_W-1:0] a31;
        logic [S1_SIGN_W-1:0] b31;
    } s1_t;

    // Final result as presented to the consumer.
    typedef struct packed {
        logic [CLA_WIDTH-1:0] sum;
        logic                 cout;
        logic                 ovf;
    } s2_t;

    // Signed overflow: operands agree in sign but the result does not.
    function automatic logic signed_ovf(input logic a_msb, input logic b_msb,
                                        input logic s_msb);
        return (a_msb == b_msb) && (s_msb != a_msb);
    endfunction

endpackage

// File: rtl/cla_add32_pipe_if.sv
// Operand/result handshake bus for cla_add32_pipe.
interface cla_add32_pipe_if import cla_add32_pipe_pkg::*;;

    logic                 in_valid;
    logic                 in_ready;
    logic [CLA_WIDTH-1:0] in_a;
    logic [CLA_WIDTH-1:0] in_b;
    logic                 cin;
    logic                 out_valid;
    logic                 out_ready;
    logic [CLA_WIDTH-1:0] out_sum;
    logic                 out_cout;
    logic                 out_ovf;

    // Producer/consumer side (drives operands, accepts results)
    modport master (
        output in_valid, in_a, in_b, cin, out_ready,
        input  in_ready, out_valid, out_sum, out_cout, out_ovf
    );

    // Adder side
    modport slave (
        input  in_valid, in_a, in_b, cin, out_ready,
        output in_ready, out_valid, out_sum, out_cout, out_ovf
    );

endinterface

// File: rtl/cla_add32_pipe_cla16.sv
// 16-bit carry-lookahead adder: four 4-bit groups with a second-level lookahead
// across the group generate/propagate terms.
module cla_16bit (
    input  logic [15:0] a_i,
    input  logic [15:0] b_i,
    input  logic        cin_i,
    output logic [15:0] sum_o,
    output logic        cout_o
);

    logic [15:0] g;
    logic [15:0] p;
    logic [3:0]  gg;
    logic [3:0]  gp;
    logic [4:0]  gc;
    logic [15:0] c;

    assign g = a_i & b_i;
    assign p = a_i ^ b_i;

    // Group generate/propagate for each 4-bit slice
    always_comb begin
        gg = '0;
        gp = '0;
        for (int k = 0; k < 4; k++) begin
            gg[k] = g[4*k+3]
                  | (p[4*k+3] & g[4*k+2])
                  | (p[4*k+3] & p[4*k+2] & g[4*k+1])
                  | (p[4*k+3] & p[4*k+2] & p[4*k+1] & g[4*k]);
            gp[k] = &p[4*k +: 4];
        end
    end

    // Second-level lookahead: group carries come straight from cin, no ripple
    assign gc[0] = cin_i;
    assign gc[1] = gg[0] | (gp[0] & cin_i);
    assign gc[2] = gg[1] | (gp[1] & gg[0]) | (gp[1] & gp[0] & cin_i);
    assign gc[3] = gg[2] | (gp[2] & gg[1]) | (gp[2] & gp[1] & gg[0])
                 | (gp[2] & gp[1] & gp[0] & cin_i);
    assign gc[4] = gg[3] | (gp[3] & gg[2]) | (gp[3] & gp[2] & gg[1])
                 | (gp[3] & gp[2] & gp[1] & gg[0])
                 | (gp[3] & gp[2] & gp[1] & gp[0] & cin_i);

    // Bit carries inside each group, seeded by that group's lookahead carry
    always_comb begin
        c = '0;
        for (int k = 0; k < 4; k++) begin
            c[4*k] = gc[k];
            for (int j = 0; j < 3; j++) begin
                c[4*k+j+1] = g[4*k+j] | (p[4*k+j] & c[4*k+j]);
            end
        end
    end

    assign sum_o  = p ^ c;
    assign cout_o = gc[4];

endmodule

// File: rtl/cla_add32_pipe.sv
// Two-stage pipelined 32-bit adder: stage 1 adds the low halves and registers
// the bit-15 carry, stage 2 adds the high halves with that carry. Valid/ready
// handshake on both sides, one result per cycle when the consumer keeps up.
module cla_add32_pipe
    import cla_add32_pipe_pkg::*;
#(
    parameter int HALF = CLA_HALF
) (
    input  logic              CLK,
    input  logic              reset,
    input  logic              flush,
    cla_add32_pipe_if.slave   bus
);

    localparam int WIDTH = 2 * HALF;

    // The datapath is two fixed 16-bit slices; any other width cannot build.
    if (HALF != CLA_HALF) begin : g_half_check
        $error("cla_add32_pipe: HALF must be 16 to match cla_16bit");
    end

    logic v1_q, v1_d;
    logic v2_q, v2_d;
    s1_t  s1_q, s1_d;
    s2_t  s2_q, s2_d;

    logic en1, en2, in_ready_w, accept;

    logic [HALF-1:0] lo_sum;
    logic            lo_cout;
    logic [HALF-1:0] hi_sum;
    logic            hi_cout;

    // A stage can take new data when it is empty or its contents move on
    // this edge; in_ready therefore follows out_ready combinationally.
    assign en2        = !v2_q | bus.out_ready;
    assign en1        = !v1_q | en2;
    assign in_ready_w = en1 & !flush & !reset;
    assign accept     = bus.in_valid & in_ready_w;

    cla_16bit u_cla_lo (
        .a_i    (bus.in_a[HALF-1:0]),
        .b_i    (bus.in_b[HALF-1:0]),
        .cin_i  (bus.cin),
        .sum_o  (lo_sum),
        .cout_o (lo_cout)
    );

    cla_16bit u_cla_hi (
        .a_i    (s1_q.a_hi),
        .b_i    (s1_q.b_hi),
        .cin_i  (s1_q.c16),
        .sum_o  (hi_sum),
        .cout_o (hi_cout)
    );

    // Valid-bit next state: flush empties both stages, otherwise shift/accept
    always_comb begin
        v1_d = v1_q;
        v2_d = v2_q;
        if (flush) begin
            v1_d = 1'b0;
            v2_d = 1'b0;
        end else begin
            if (en2) v2_d = v1_q;
            if (en1) v1_d = accept;
        end
    end

    // Valid-bit registers
    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            v1_q <= 1'b0;
            v2_q <= 1'b0;
        end else begin
            v1_q <= v1_d;
            v2_q <= v2_d;
        end
    end

    // Data next state: S1 loads only on a real accept so idle inputs never
    // leak in; S2 holds whenever the consumer is stalling.
    always_comb begin
        s1_d = s1_q;
        s2_d = s2_q;
        if (accept) begin
            s1_d = '{lo_sum: lo_sum,
                     c16:    lo_cout,
                     a_hi:   bus.in_a[WIDTH-1:HALF],
                     b_hi:   bus.in_b[WIDTH-1:HALF],
                     a31:    bus.in_a[WIDTH-1],
                     b31:    bus.in_b[WIDTH-1]};
        end
        if (en2) begin
            s2_d = '{sum:  {hi_sum, s1_q.lo_sum},
                     cout: hi_cout,
                     ovf:  signed_ovf(s1_q.a31, s1_q.b31, hi_sum[HALF-1])};
        end
    end

    // Stage data registers
    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            s1_q <= '0;
            s2_q <= '0;
        end else begin
            s1_q <= s1_d;
            s2_q <= s2_d;
        end
    end

    assign bus.in_ready  = in_ready_w;
    assign bus.out_valid = v2_q;
    assign bus.out_sum   = s2_q.sum;
    assign bus.out_cout  = s2_q.cout;
    assign bus.out_ovf   = s2_q.ovf;

endmodule

// File: tb/tb_cla_add32_pipe.sv
// Self-checking bench for cla_add32_pipe: directed vectors, backpressure,
// async reset, flush and a randomly stalled scoreboard run.
module tb_cla_add32_pipe;
    import cla_add32_pipe_pkg::*;

    logic clk = 1'b0;
    logic reset;
    logic flush;

    cla_add32_pipe_if bus();

    cla_add32_pipe dut (
        .CLK   (clk),
        .reset (reset),
        .flush (flush),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Reference result packed as {cout, ovf, sum}
    function automatic logic [33:0] ref_add(input logic [31:0] a, input logic [31:0] b,
                                            input logic ci);
        logic [32:0] s;
        logic        ov;
        s  = {1'b0, a} + {1'b0, b} + {32'd0, ci};
        ov = (a[31] == b[31]) && (s[31] != a[31]);
        return {s[32], ov, s[31:0]};
    endfunction

    // Scoreboard
    logic [33:0] exp_q[$];
    int n_acc  = 0;
    int n_pop  = 0;
    int n_drop = 0;

    always @(posedge reset) begin
        n_drop += exp_q.size();
        exp_q.delete();
    end

    always @(negedge clk) begin
        logic [33:0] e;
        if (reset) begin
            n_drop += exp_q.size();
            exp_q.delete();
        end else begin
            if (bus.out_valid && bus.out_ready) begin
                n_pop++;
                if (exp_q.size() == 0) begin
                    chk("sb_spurious", 64'd1, 64'd0);
                end else begin
                    e = exp_q.pop_front();
                    chk("sb_result", {bus.out_cout, bus.out_ovf, bus.out_sum}, e);
                end
            end
            if (flush) begin
                n_drop += exp_q.size();
                exp_q.delete();
            end
            if (bus.in_valid && bus.in_ready) begin
                n_acc++;
                exp_q.push_back(ref_add(bus.in_a, bus.in_b, bus.cin));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [31:0] a, input logic [31:0] b, input logic ci);
        bus.in_valid = 1'b1;
        bus.in_a     = a;
        bus.in_b     = b;
        bus.cin      = ci;
    endtask

    task automatic idle();
        bus.in_valid = 1'b0;
    endtask

    // One op through an empty pipe: accepted at edge N, result visible after N+1
    task automatic directed(input string nm, input logic [31:0] a, input logic [31:0] b,
                            input logic ci, input logic [31:0] es, input logic ec,
                            input logic eo);
        tick();
        drive(a, b, ci);
        @(negedge clk);
        chk({nm, "_in_ready"}, bus.in_ready, 1);
        tick();
        idle();
        @(negedge clk);
        chk({nm, "_early_valid"}, bus.out_valid, 0);
        @(negedge clk);
        chk({nm, "_valid"}, bus.out_valid, 1);
        chk({nm, "_sum"}, bus.out_sum, es);
        chk({nm, "_cout"}, bus.out_cout, ec);
        chk({nm, "_ovf"}, bus.out_ovf, eo);
    endtask

    // Fill both stages with out_ready low
    task automatic fill_pipe(input logic [31:0] x, input logic [31:0] y);
        bus.out_ready = 1'b0;
        tick();
        drive(x, 32'h1, 1'b0);
        tick();
        drive(y, 32'h2, 1'b0);
        tick();
        idle();
    endtask

    function automatic logic [31:0] rand_op();
        logic [31:0] x;
        x = $urandom;
        case ($urandom_range(0, 3))
            0: x[15:0] = 16'hFFFF;
            1: x[30:0] = {31{x[0]}};
            default: ;
        endcase
        return x;
    endfunction

    logic [31:0] ta[8];
    logic [31:0] tb_op[8];
    logic        tc[8];

    initial begin
        int acc;
        int pop0;
        int sent;
        int cyc;
        logic acc_r;

        reset         = 1'b1;
        flush         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_a      = '0;
        bus.in_b      = '0;
        bus.cin       = 1'b0;
        bus.out_ready = 1'b1;

        // Reset state
        #12;
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_out_sum", bus.out_sum, 0);
        chk("rst_out_cout", bus.out_cout, 0);
        chk("rst_out_ovf", bus.out_ovf, 0);
        chk("rst_in_ready", bus.in_ready, 0);
        #1 reset = 1'b0;
        #1 chk("rst_rel_in_ready", bus.in_ready, 1);

        // T1..T3 directed
        directed("t1", 32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 32'h0000_0000, 1'b1, 1'b0);
        directed("t2", 32'h0000_FFFF, 32'h0000_0001, 1'b0, 32'h0001_0000, 1'b0, 1'b0);
        directed("t3a", 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 32'h8000_0000, 1'b0, 1'b1);
        directed("t3b", 32'h8000_0000, 32'h8000_0000, 1'b0, 32'h0000_0000, 1'b1, 1'b1);
        directed("mix", 32'h1234_5678, 32'h8765_4321, 1'b0, 32'h9999_9999, 1'b0, 1'b0);
        tick();
        tick();

        // T4 back-to-back, then backpressure
        for (int i = 0; i < 8; i++) begin
            ta[i]    = rand_op();
            tb_op[i] = rand_op();
            tc[i]    = 1'($urandom_range(0, 1));
        end
        pop0 = n_pop;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            drive(ta[i], tb_op[i], tc[i]);
            @(negedge clk);
            chk("b2b_in_ready", bus.in_ready, 1);
            if (i >= 2) chk("b2b_out_valid", bus.out_valid, 1);
            tick();
        end
        idle();
        @(negedge clk);
        chk("b2b_out_valid", bus.out_valid, 1);
        tick();
        @(negedge clk);
        chk("b2b_out_valid", bus.out_valid, 1);
        tick();
        @(negedge clk);
        chk("b2b_drained", bus.out_valid, 0);
        chk("b2b_pops", n_pop - pop0, 8);

        pop0 = n_pop;
        drive(32'h0000_0001, 32'h0000_0002, 1'b1);
        tick();
        idle();
        tick();
        bus.out_ready = 1'b0;
        drive(32'h0000_0010, 32'h0000_0020, 1'b0);
        acc = 0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("bp_valid", bus.out_valid, 1);
            chk("bp_sum", bus.out_sum, 32'h0000_0004);
            chk("bp_cout", bus.out_cout, 0);
            if (k == 0) chk("bp_first_ready", bus.in_ready, 1);
            else chk("bp_in_ready", bus.in_ready, 0);
            if (bus.in_valid && bus.in_ready) acc++;
            tick();
            if (k == 0) drive(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
        end
        chk("bp_accepts", acc, 1);
        bus.out_ready = 1'b1;
        @(negedge clk);
        chk("bp_passthru_ready", bus.in_ready, 1);
        tick();
        idle();
        repeat (4) tick();
        chk("bp_pops", n_pop - pop0, 3);
        chk("bp_sb_empty", exp_q.size(), 0);

        // T5 async reset with both stages valid
        fill_pipe(32'h1111_1111, 32'h2222_2222);
        @(negedge clk);
        chk("rst5_pre_valid", bus.out_valid, 1);
        chk("rst5_full_ready", bus.in_ready, 0);
        #2 reset = 1'b1;
        #1;
        chk("rst5_async_valid", bus.out_valid, 0);
        chk("rst5_async_sum", bus.out_sum, 0);
        chk("rst5_in_ready", bus.in_ready, 0);
        @(posedge clk);
        #3 reset = 1'b0;
        bus.out_ready = 1'b1;
        #1 chk("rst5_rel_ready", bus.in_ready, 1);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("rst5_no_stale", bus.out_valid, 0);
        end
        tick();

        // T6 flush with a full pipe and a pending input
        fill_pipe(32'h3333_3333, 32'h4444_4444);
        drive(32'h5555_5555, 32'h0000_0001, 1'b0);
        flush = 1'b1;
        @(negedge clk);
        chk("flush_in_ready", bus.in_ready, 0);
        tick();
        flush = 1'b0;
        idle();
        bus.out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("flush_out_valid", bus.out_valid, 0);
        end
        directed("post_flush", 32'h0000_FFFF, 32'h0000_FFFF, 1'b1, 32'h0001_FFFF, 1'b0, 1'b0);
        tick();
        tick();

        // Random stalls with scoreboard
        sent  = 0;
        cyc   = 0;
        acc_r = 1'b1;
        idle();
        while (sent < 1000 && cyc < 20000) begin
            if (acc_r || !bus.in_valid) begin
                bus.in_a     = rand_op();
                bus.in_b     = rand_op();
                bus.cin      = 1'($urandom_range(0, 1));
                bus.in_valid = ($urandom_range(0, 3) != 0);
            end
            bus.out_ready = ($urandom_range(0, 3) != 0);
            @(negedge clk);
            acc_r = bus.in_valid && bus.in_ready;
            if (acc_r) sent++;
            tick();
            cyc++;
        end
        chk("rand_sent", sent, 1000);
        idle();
        bus.out_ready = 1'b1;
        for (int k = 0; k < 50; k++) begin
            if (exp_q.size() == 0) break;
            tick();
        end
        tick();
        chk("final_sb_empty", exp_q.size(), 0);
        chk("final_balance", n_pop + n_drop, n_acc);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, %0d tests run", n_tests);
        $fatal(1, "watchdog timeout");
    end

endmodule
